timer_master: RTL

Bus initiator that drives the 16-bit timer peripheral's register port to produce hardware-timed delays for logic that is not the CPU. On a `start` pulse it clears, loads, arms and polls the timer over the 2-bit register bus, stops the timer, then pulses `done`. It sits between a local requester (DMA pacing, sound sequencing) and a dedicated timer instance, and owns that timer's bus.

---
 rtl/timer_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/timer_master.sv
// timer_master: drives a 16-bit timer's register bus to time a delay.
// Optional feature macro: TIMER_MASTER_PERIODIC_EN (auto-reload runs).
module timer_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
`ifdef TIMER_MASTER_PERIODIC_EN
  input  logic        periodic,
`endif
  input  logic [15:0] delay,
  output logic        busy,
  output logic        done,
  output logic [1:0]  addr,
  output logic [7:0]  dbw,
  output logic        we,
  input  logic [7:0]  dbr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LO,
    S_HI,
    S_ARM,
    S_SETTLE,
    S_POLL,
    S_STOP,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] delay_q, delay_d;
  logic        aborted_q, aborted_d;
  logic        periodic_q, periodic_d;

  logic        busy_d, done_d, we_d;
  logic [1:0]  addr_d;
  logic [7:0]  dbw_d;

  logic        shot;
  logic        req_periodic;
  logic        dbr_unused;

  assign shot       = dbr[7];
  assign dbr_unused = ^dbr[6:0];

`ifdef TIMER_MASTER_PERIODIC_EN
  assign req_periodic = periodic;
`else
  assign req_periodic = 1'b0;
`endif

  // Next-state: sequence the bus transactions, abort diverts to STOP.
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    aborted_d  = aborted_q;
    periodic_d = periodic_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_CLR;
          delay_d    = delay;
          aborted_d  = 1'b0;
          periodic_d = req_periodic;
        end
      end
      S_CLR, S_LO, S_HI, S_ARM, S_SETTLE: begin
        if (abort) begin
          state_d   = S_STOP;
          aborted_d = 1'b1;
        end else begin
          unique case (state_q)
            S_CLR:   state_d = S_LO;
            S_LO:    state_d = S_HI;
            S_HI:    state_d = S_ARM;
            S_ARM:   state_d = S_SETTLE;
            default: state_d = S_POLL;
          endcase
        end
      end
      S_POLL: begin
        if (abort) begin
          state_d   = S_STOP;
          aborted_d = 1'b1;
        end else if (shot) begin
          state_d = periodic_q ? S_CLR : S_STOP;
        end
      end
      S_STOP: begin
        state_d = aborted_q ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    we_d   = 1'b0;
    addr_d = 2'd0;
    dbw_d  = 8'h00;
    unique case (state_d)
      S_CLR: begin
        we_d   = 1'b1;
        addr_d = 2'd2;
        done_d = (state_q == S_POLL);
      end
      S_LO: begin
        we_d   = 1'b1;
        addr_d = 2'd0;
        dbw_d  = delay_d[7:0];
      end
      S_HI: begin
        we_d   = 1'b1;
        addr_d = 2'd1;
        dbw_d  = delay_d[15:8];
      end
      S_ARM: begin
        we_d   = 1'b1;
        addr_d = 2'd2;
        dbw_d  = 8'h01;
      end
      S_SETTLE, S_POLL: begin
        addr_d = 2'd2;
      end
      S_STOP: begin
        we_d   = 1'b1;
        addr_d = 2'd2;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // State, run context and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      delay_q    <= 16'h0000;
      aborted_q  <= 1'b0;
      periodic_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      we         <= 1'b0;
      addr       <= 2'd0;
      dbw        <= 8'h00;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      aborted_q  <= aborted_d;
      periodic_q <= periodic_d;
      busy       <= busy_d;
      done       <= done_d;
      we         <= we_d;
      addr       <= addr_d;
      dbw        <= dbw_d;
    end
  end

endmodule
